// File: rtl/dmrs_seq_ctrl_if.sv
// Sample stream from the DMRS phase sequencer toward the DMRS mapper.
// The master drives the registered sample fields; the slave returns out_ready.
interface dmrs_seq_ctrl_if #(
    parameter int SYM_W = 2
);
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_phi;
    logic [3:0]       out_shift;
    logic [3:0]       out_k;
    logic [SYM_W-1:0] out_sym;
    logic             out_last;

    modport master (
        output out_valid, out_phi, out_shift, out_k, out_sym, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_phi, out_shift, out_k, out_sym, out_last,
        output out_ready
    );
endinterface

// File: rtl/dmrs_seq_ctrl.sv
// Walks the length-12 low-PAPR phase table once per DMRS symbol and streams each
// phase code with its cyclic-shift phase (cs*n mod 12) to the DMRS mapper.
module dmrs_seq_ctrl #(
    parameter int N_SC  = 12,
    parameter int SYM_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [4:0]       cfg_u,
    input  logic [3:0]       cfg_cs,
    input  logic [SYM_W-1:0] cfg_nsym,
    output logic [4:0]       tbl_u,
    output logic [9:0]       tbl_cnt,
    input  logic [1:0]       tbl_phi,
    dmrs_seq_ctrl_if.master  out_if,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    localparam logic [3:0] K_LAST = 4'(N_SC - 1);
    localparam logic [4:0] SC_MOD = 5'(N_SC);
    localparam logic [4:0] U_MAX  = 5'd29;
    localparam logic [3:0] CS_MAX = 4'd11;

    state_e           state_q, state_d;
    logic [4:0]       u_q, u_d;
    logic [3:0]       cs_q, cs_d;
    logic [SYM_W-1:0] nsym_q, nsym_d;
    logic [3:0]       n_q, n_d;
    logic [SYM_W-1:0] sym_q, sym_d;
    logic [3:0]       acc_q, acc_d;

    logic             out_valid_q, out_valid_d;
    logic [1:0]       out_phi_q, out_phi_d;
    logic [3:0]       out_shift_q, out_shift_d;
    logic [3:0]       out_k_q, out_k_d;
    logic [SYM_W-1:0] out_sym_q, out_sym_d;
    logic             out_last_q, out_last_d;
    logic             done_q, done_d;
    logic             cfg_err_q, cfg_err_d;

    logic             out_free;
    logic             cfg_ok;
    logic             last_elem;
    logic [4:0]       acc_sum;

    assign out_free  = !out_valid_q || out_if.out_ready;
    assign cfg_ok    = (cfg_u <= U_MAX) && (cfg_cs <= CS_MAX);
    assign last_elem = (n_q == K_LAST) && (sym_q == nsym_q);
    assign acc_sum   = {1'b0, acc_q} + {1'b0, cs_q};

    always_comb begin
        // NOTE: every *_d gets a default before the case so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        u_d         = u_q;
        cs_d        = cs_q;
        nsym_d      = nsym_q;
        n_d         = n_q;
        sym_d       = sym_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_phi_d   = out_phi_q;
        out_shift_d = out_shift_q;
        out_k_d     = out_k_q;
        out_sym_d   = out_sym_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (cfg_ok) begin
                        u_d     = cfg_u;
                        cs_d    = cfg_cs;
                        nsym_d  = cfg_nsym;
                        n_d     = '0;
                        sym_d   = '0;
                        acc_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                // Output register and pointers move together, so a stall freezes both.
                if (out_free) begin
                    out_phi_d   = tbl_phi;
                    out_shift_d = acc_q;
                    out_k_d     = n_q;
                    out_sym_d   = sym_q;
                    out_last_d  = last_elem;
                    out_valid_d = 1'b1;
                    if (n_q == K_LAST) begin
                        n_d   = '0;
                        sym_d = sym_q + 1'b1;
                        acc_d = '0;
                    end else begin
                        n_d   = n_q + 4'd1;
                        acc_d = (acc_sum >= SC_MOD) ? 4'(acc_sum - SC_MOD) : acc_sum[3:0];
                    end
                    if (last_elem) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (out_valid_q && out_if.out_ready) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Abort outranks start and a pending handshake.
        if (abort) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            done_d      = 1'b0;
            cfg_err_d   = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            u_q         <= '0;
            cs_q        <= '0;
            nsym_q      <= '0;
            n_q         <= '0;
            sym_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_phi_q   <= '0;
            out_shift_q <= '0;
            out_k_q     <= '0;
            out_sym_q   <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            u_q         <= u_d;
            cs_q        <= cs_d;
            nsym_q      <= nsym_d;
            n_q         <= n_d;
            sym_q       <= sym_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_phi_q   <= out_phi_d;
            out_shift_q <= out_shift_d;
            out_k_q     <= out_k_d;
            out_sym_q   <= out_sym_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign tbl_u            = u_q;
    assign tbl_cnt          = {6'b0, n_q};
    assign busy             = (state_q != ST_IDLE);
    assign done             = done_q;
    assign cfg_err          = cfg_err_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_phi   = out_phi_q;
    assign out_if.out_shift = out_shift_q;
    assign out_if.out_k     = out_k_q;
    assign out_if.out_sym   = out_sym_q;
    assign out_if.out_last  = out_last_q;

endmodule

// File: tb/tb_dmrs_seq_ctrl.sv
// Directed bench for dmrs_seq_ctrl; the bench also plays the combinational phase table.
module tb_dmrs_seq_ctrl;

    localparam int SYM_W  = 2;
    localparam int OUTS_W = 30 + SYM_W;

    typedef struct packed {
        logic [1:0]       phi;
        logic [3:0]       shift;
        logic [3:0]       k;
        logic [SYM_W-1:0] sym;
        logic             last;
    } samp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [4:0]       cfg_u;
    logic [3:0]       cfg_cs;
    logic [SYM_W-1:0] cfg_nsym;
    logic [4:0]       tbl_u;
    logic [9:0]       tbl_cnt;
    logic [1:0]       tbl_phi;
    logic             busy;
    logic             done;
    logic             cfg_err;

    int checks = 0;
    int errors = 0;

    samp_t got[$];
    int    iters;
    int    stab_bad;
    bit    timeout;

    logic [1:0] row_u0  [12] = '{2'd3, 2'd0, 2'd3, 2'd3, 2'd3, 2'd1, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0, 2'd3};
    logic [1:0] row_u6  [12] = '{2'd0, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0, 2'd3};
    logic [1:0] row_u29 [12] = '{2'd3, 2'd1, 2'd3, 2'd1, 2'd3, 2'd3, 2'd1, 2'd2, 2'd2, 2'd0, 2'd1, 2'd3};

    dmrs_seq_ctrl_if #(.SYM_W(SYM_W)) out_if ();

    dmrs_seq_ctrl #(.N_SC(12), .SYM_W(SYM_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .cfg_u    (cfg_u),
        .cfg_cs   (cfg_cs),
        .cfg_nsym (cfg_nsym),
        .tbl_u    (tbl_u),
        .tbl_cnt  (tbl_cnt),
        .tbl_phi  (tbl_phi),
        .out_if   (out_if),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] table_phi(input logic [4:0] u, input logic [9:0] c);
        if (c > 10'd11) return 2'd0;
        case (u)
            5'd0:    return row_u0[c[3:0]];
            5'd6:    return row_u6[c[3:0]];
            5'd29:   return row_u29[c[3:0]];
            default: return 2'(int'(u) + int'(c));
        endcase
    endfunction

    assign tbl_phi = table_phi(tbl_u, tbl_cnt);

    function automatic samp_t exp_samp(input int u, input int cs, input int nsym, input int i);
        samp_t r;
        int    k;
        int    s;
        k = i % 12;
        s = i / 12;
        r = {table_phi(5'(u), 10'(k)), 4'((k * cs) % 12), 4'(k), SYM_W'(s), (i == 12 * (nsym + 1) - 1)};
        return r;
    endfunction

    function automatic samp_t cur();
        samp_t r;
        r = {out_if.out_phi, out_if.out_shift, out_if.out_k, out_if.out_sym, out_if.out_last};
        return r;
    endfunction

    function automatic logic [OUTS_W-1:0] all_outs();
        return {out_if.out_valid, out_if.out_phi, out_if.out_shift, out_if.out_k, out_if.out_sym,
                out_if.out_last, busy, done, cfg_err, tbl_u, tbl_cnt};
    endfunction

    function automatic int seq_errs(input int u, input int cs, input int nsym, output int first);
        int nb;
        nb    = 0;
        first = -1;
        foreach (got[i]) begin
            if (got[i] !== exp_samp(u, cs, nsym, i)) begin
                if (nb == 0) first = i;
                nb++;
            end
        end
        return nb;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq(input logic [4:0] u, input logic [3:0] cs, input logic [SYM_W-1:0] ns);
        cfg_u    = u;
        cfg_cs   = cs;
        cfg_nsym = ns;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        // Scramble the config after acceptance; the running sequence must ignore it.
        cfg_u    = 5'd17;
        cfg_cs   = 4'd7;
        cfg_nsym = ~ns;
    endtask

    // Records accepted samples until the last one is taken; counts held-sample changes.
    task automatic collect(input int duty, input int max_cyc);
        samp_t held;
        bit    holding;
        bit    fin;
        got.delete();
        iters    = 0;
        stab_bad = 0;
        timeout  = 1'b0;
        fin      = 1'b0;
        while (!fin) begin
            if (iters >= max_cyc) begin
                timeout = 1'b1;
                break;
            end
            out_if.out_ready = (int'($urandom_range(0, 99)) < duty);
            holding = out_if.out_valid && !out_if.out_ready;
            held    = cur();
            if (out_if.out_valid && out_if.out_ready) begin
                got.push_back(held);
                fin = held.last;
            end
            tick();
            iters++;
            if (holding && (out_if.out_valid !== 1'b1 || cur() !== held)) stab_bad++;
        end
        out_if.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_outs got=%h exp=0", all_outs());
        end
        rst = 1'b0;
        tick();
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_idle got=%h exp=0", all_outs());
        end
    endtask

    task automatic test_basic();
        int nb;
        int first;
        out_if.out_ready = 1'b1;
        start_seq(5'd0, 4'd0, '0);
        checks++;
        if (busy !== 1'b1 || out_if.out_valid !== 1'b0 || tbl_cnt !== 10'd0 || tbl_u !== 5'd0) begin
            errors++;
            $display("FAIL basic_t1 busy=%b valid=%b cnt=%0d exp busy=1 valid=0 cnt=0", busy, out_if.out_valid, tbl_cnt);
        end
        collect(100, 40);
        checks++;
        if (timeout || got.size() !== 12) begin
            errors++;
            $display("FAIL basic_count got=%0d timeout=%b exp=12", got.size(), timeout);
        end
        checks++;
        if (iters !== 13) begin
            errors++;
            $display("FAIL basic_latency cycles=%0d exp=13", iters);
        end
        checks++;
        nb = seq_errs(0, 0, 0, first);
        if (nb !== 0) begin
            errors++;
            $display("FAIL basic_seq bad=%0d idx=%0d got=%h exp=%h", nb, first, got[first], exp_samp(0, 0, 0, first));
        end
        checks++;
        if ({done, busy, out_if.out_valid} !== 3'b100) begin
            errors++;
            $display("FAIL basic_done done/busy/valid=%b exp=100", {done, busy, out_if.out_valid});
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse done=%b exp=0", done);
        end
    endtask

    task automatic test_shift_multi();
        int nb;
        int first;
        out_if.out_ready = 1'b1;
        start_seq(5'd29, 4'd5, SYM_W'(1));
        collect(100, 60);
        checks++;
        if (timeout || got.size() !== 24) begin
            errors++;
            $display("FAIL multi_count got=%0d timeout=%b exp=24", got.size(), timeout);
        end
        checks++;
        if (iters !== 25) begin
            errors++;
            $display("FAIL multi_bubbles cycles=%0d exp=25", iters);
        end
        checks++;
        nb = seq_errs(29, 5, 1, first);
        if (nb !== 0) begin
            errors++;
            $display("FAIL multi_seq bad=%0d idx=%0d got=%h exp=%h", nb, first, got[first], exp_samp(29, 5, 1, first));
        end
        tick();
    endtask

    task automatic test_backpressure();
        int nb;
        int first;
        start_seq(5'd6, 4'd1, '0);
        collect(50, 300);
        checks++;
        if (timeout || got.size() !== 12) begin
            errors++;
            $display("FAIL bp_count got=%0d timeout=%b exp=12", got.size(), timeout);
        end
        checks++;
        if (stab_bad !== 0) begin
            errors++;
            $display("FAIL bp_stable changes=%0d exp=0", stab_bad);
        end
        checks++;
        nb = seq_errs(6, 1, 0, first);
        if (nb !== 0) begin
            errors++;
            $display("FAIL bp_seq bad=%0d idx=%0d got=%h exp=%h", nb, first, got[first], exp_samp(6, 1, 0, first));
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL bp_done done=%b exp=1", done);
        end
        tick();
    endtask

    task automatic test_cfg_err();
        int nb;
        int first;
        logic [4:0] bad_u  [2] = '{5'd30, 5'd3};
        logic [3:0] bad_cs [2] = '{4'd2, 4'd12};
        for (int i = 0; i < 2; i++) begin
            cfg_u  = bad_u[i];
            cfg_cs = bad_cs[i];
            start  = 1'b1;
            tick();
            start  = 1'b0;
            checks++;
            if ({cfg_err, busy, out_if.out_valid, done} !== 4'b1000) begin
                errors++;
                $display("FAIL cfgerr_pulse%0d err/busy/valid/done=%b exp=1000", i, {cfg_err, busy, out_if.out_valid, done});
            end
            tick();
            checks++;
            if ({cfg_err, busy, out_if.out_valid, done} !== 4'b0000) begin
                errors++;
                $display("FAIL cfgerr_after%0d err/busy/valid/done=%b exp=0000", i, {cfg_err, busy, out_if.out_valid, done});
            end
        end
        start_seq(5'd0, 4'd3, '0);
        collect(100, 40);
        checks++;
        nb = seq_errs(0, 3, 0, first);
        if (timeout || got.size() !== 12 || nb !== 0) begin
            errors++;
            $display("FAIL cfgerr_recover count=%0d bad=%0d timeout=%b exp count=12 bad=0", got.size(), nb, timeout);
        end
        tick();
    endtask

    task automatic test_abort_reset();
        int nb;
        int first;
        out_if.out_ready = 1'b1;
        start_seq(5'd6, 4'd1, '0);
        for (int i = 0; i < 20 && !(out_if.out_valid && out_if.out_k == 4'd5); i++) tick();
        out_if.out_ready = 1'b0;
        tick();
        checks++;
        if (out_if.out_valid !== 1'b1 || out_if.out_k !== 4'd5) begin
            errors++;
            $display("FAIL abort_setup valid=%b k=%0d exp valid=1 k=5", out_if.out_valid, out_if.out_k);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({out_if.out_valid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL abort_idle valid/busy/done=%b exp=000", {out_if.out_valid, busy, done});
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done done=%b exp=0", done);
        end
        start_seq(5'd6, 4'd1, '0);
        collect(100, 40);
        checks++;
        nb = seq_errs(6, 1, 0, first);
        if (timeout || got.size() !== 12 || nb !== 0) begin
            errors++;
            $display("FAIL abort_restart count=%0d bad=%0d timeout=%b exp count=12 bad=0", got.size(), nb, timeout);
        end
        tick();

        start_seq(5'd29, 4'd5, SYM_W'(1));
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL rst_mid got=%h exp=0", all_outs());
        end
        tick();
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL rst_mid_idle got=%h exp=0", all_outs());
        end
        start_seq(5'd0, 4'd0, '0);
        collect(100, 40);
        checks++;
        nb = seq_errs(0, 0, 0, first);
        if (timeout || got.size() !== 12 || nb !== 0 || iters !== 13) begin
            errors++;
            $display("FAIL rst_restart count=%0d bad=%0d cycles=%0d exp count=12 bad=0 cycles=13", got.size(), nb, iters);
        end
        tick();
    endtask

    task automatic test_collisions();
        int nb;
        int first;
        out_if.out_ready = 1'b0;
        start_seq(5'd0, 4'd0, '0);
        cfg_u  = 5'd29;
        cfg_cs = 4'd5;
        start  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (cfg_err !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_start_err%0d cfg_err=%b busy=%b exp 0/1", i, cfg_err, busy);
            end
        end
        start = 1'b0;
        collect(100, 40);
        checks++;
        nb = seq_errs(0, 0, 0, first);
        if (timeout || got.size() !== 12 || nb !== 0) begin
            errors++;
            $display("FAIL busy_start_seq count=%0d bad=%0d timeout=%b exp count=12 bad=0", got.size(), nb, timeout);
        end

        // Now in the done cycle: a start here must be taken.
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_cycle done=%b exp=1", done);
        end
        start_seq(5'd29, 4'd5, '0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_on_done busy=%b exp=1", busy);
        end
        collect(100, 40);
        checks++;
        nb = seq_errs(29, 5, 0, first);
        if (timeout || got.size() !== 12 || nb !== 0 || iters !== 13) begin
            errors++;
            $display("FAIL start_on_done_seq count=%0d bad=%0d cycles=%0d exp count=12 bad=0 cycles=13", got.size(), nb, iters);
        end
        tick();

        cfg_u  = 5'd0;
        cfg_cs = 4'd0;
        start  = 1'b1;
        abort  = 1'b1;
        tick();
        start  = 1'b0;
        abort  = 1'b0;
        checks++;
        if ({busy, cfg_err} !== 2'b00) begin
            errors++;
            $display("FAIL start_abort busy/cfg_err=%b exp=00", {busy, cfg_err});
        end
        tick();
        checks++;
        if ({busy, out_if.out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL start_abort_idle busy/valid=%b exp=00", {busy, out_if.out_valid});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst              = 1'b1;
        start            = 1'b0;
        abort            = 1'b0;
        cfg_u            = '0;
        cfg_cs           = '0;
        cfg_nsym         = '0;
        out_if.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_shift_multi();
        test_backpressure();
        test_cfg_err();
        test_abort_reset();
        test_collisions();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmrs_seq_ctrl.md
# dmrs_seq_ctrl

Sequencer for the length-12 low-PAPR phase table used by PUSCH DMRS generation. It accepts a group number, cyclic-shift index and DMRS symbol count. It then walks the phase table (`tbl_u` / `tbl_cnt` → `tbl_phi`) once per DMRS symbol. Each table read is emitted as a registered sample on a valid/ready stream, together with the cyclic-shift phase (α·n in units of 2π/12), toward the DMRS mapper.

## Interface
- `N_SC`, default 12: sequence length per symbol. Fixed at 12 for this table.
- `SYM_W`, default 2: width of the symbol count and symbol index (up to 4 DMRS symbols).
- `clk` in 1: clock, rising-edge.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `start` in 1: request a new sequence. Sampled only in IDLE.
- `abort` in 1: synchronous abort. Returns the block to IDLE.
- `cfg_u` in 5: sequence group number, valid range 0..29.
- `cfg_cs` in 4: cyclic-shift index, valid range 0..11.
- `cfg_nsym` in SYM_W: number of DMRS symbols minus 1.
- `tbl_u` out 5: group number driven to the phase table.
- `tbl_cnt` out 10: element index driven to the phase table, range 0..11.
- `tbl_phi` in 2: table phase code. Combinational response to `tbl_u` / `tbl_cnt`.
- `out_valid` out 1: output sample valid.
- `out_ready` in 1: downstream accept.
- `out_phi` out 2: phase code for element n.
- `out_shift` out 4: (cs·n) mod 12.
- `out_k` out 4: element index n, 0..11.
- `out_sym` out SYM_W: symbol index.
- `out_last` out 1: high on the final sample of the final symbol.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse on completion.
- `cfg_err` out 1: one-cycle pulse when `start` is rejected.

## Operation
- **Reset values:** all outputs are 0, state is IDLE, and `tbl_u` / `tbl_cnt` are 0.
- **IDLE, `start`=1, valid config:** latch `cfg_u`, `cfg_cs` and `cfg_nsym`, clear `n`, `sym` and `acc`, then go to RUN.
- **IDLE, `start`=1, invalid config** (`cfg_u` > 29 or `cfg_cs` > 11): pulse `cfg_err` in the next cycle and stay in IDLE.
- **`tbl_u` / `tbl_cnt`:** `tbl_u` = latched u; `tbl_cnt` = {6'b0, n}.
- **RUN, per element:** when the output register is free (`!out_valid || out_ready`), load the output register:
  - `out_phi` ← `tbl_phi`
  - `out_shift` ← `acc`
  - `out_k` ← `n`
  - `out_sym` ← `sym`
  - `out_last` ← (n==11 && sym==nsym)
  - `out_valid` ← 1
- **Pointer advance, same cycle as the load:**
  - `n` ← n+1, wrapping to 0 after 11.
  - `acc` ← (acc + cs) mod 12, computed as a 5-bit sum with 12 subtracted if the sum is ≥ 12.
  - On wrap, `sym` ← sym+1 and `acc` ← 0.
- **Last load:** loading the last element moves the state to DRAIN.
- **Stall:** when the output register is not free, `n`, `sym`, `acc` and the output register all hold. `out_*` must not change while `out_valid` && !`out_ready`.
- **DRAIN:** when `out_valid` && `out_ready` (last sample accepted):
  - `out_valid` ← 0
  - `done` pulses in the next cycle
  - state → IDLE
- **Abort:** `abort`=1 in any state → IDLE at the next edge, `out_valid` ← 0, no `done`. Abort takes priority over `start` and over a handshake in the same cycle.
- **Start while busy:** `start` in RUN or DRAIN is ignored; no error pulse.
- **`rst` mid-operation:** same effect as reset, all outputs return to their reset values.
- **Configuration changes:** changes to `cfg_*` after acceptance have no effect on the sequence in progress.

## Timing
- `start` sampled in cycle t: `busy`=1 from t+1, table addressed with n=0 in t+1, first `out_valid` in t+2.
- With `out_ready` held high: one sample per cycle, 12·(nsym+1) consecutive samples, no bubbles, including across symbol boundaries.
- Last handshake in cycle L: `out_valid`=0, `busy`=0 and `done`=1 in L+1.
- Earliest next `start` is accepted in L+1; its first sample appears in L+3.
- `cfg_err` pulses in t+1 for a rejected `start` in t. `busy` stays 0.
- Back-pressure: a deasserted `out_ready` stalls the block with zero sample loss and zero duplication.

## Test plan
- **Basic run:** u=0, cs=0, nsym=0, `out_ready`=1.
  - 12 samples; `out_phi` = 3,0,3,3,3,1,3,2,0,0,0,3.
  - `out_shift` all 0; `out_last` only at k=11.
  - `done` one cycle after the last sample; first sample at t+2.
- **Shift and multi-symbol:** u=29, cs=5, nsym=1.
  - 24 samples; `out_shift` per symbol = 0,5,10,3,8,1,6,11,4,9,2,7.
  - `out_sym` 0 then 1; `acc` restarts at 0 for symbol 1.
  - `out_phi` = 3,1,3,1,3,3,1,2,2,0,1,3 in each symbol.
- **Back-pressure:** u=6, cs=1, nsym=0.
  - Random `out_ready` with ~50% duty; held-valid samples stay stable.
  - Full sequence 0,2,1,2,2,2,3,2,0,0,0,3 delivered exactly once, in order.
- **Config errors:** `start` with u=30, then with cs=12.
  - `cfg_err` pulse each time; `busy`, `out_valid` and `done` stay 0.
  - A following valid `start` runs normally.
- **Abort and reset:**
  - `abort` at sample 5 with `out_valid`=1, `out_ready`=0 → `out_valid`=0 next cycle, no `done`.
  - `rst` mid-run → all outputs 0.
  - A new `start` after either produces a clean sequence from k=0.
- **Start/abort collisions:**
  - `start` during RUN is ignored.
  - `start` and `abort` in the same IDLE cycle → stays in IDLE.
  - `start` in the cycle of `done` is accepted.
